// File: rtl/sort_rank_seq.sv
// Iterative rank sorter: one comparison column per cycle, then a scatter into sorted slots.
// Optional descending mode is built only when SORT_RANK_DESC_EN is defined.
module sort_rank_seq #(
    parameter  int N  = 16,
    parameter  int DW = 20,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] in_data,
`ifdef SORT_RANK_DESC_EN
    input  logic            mode_desc,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] out_data,
    output logic [N*IW-1:0] out_idx,
    output logic [N*IW-1:0] out_rank,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, RANK, SCATTER, DONE} state_t;

    localparam logic [IW-1:0] J_LAST = IW'(N - 1);

    state_t        state, next_state;
    logic [DW-1:0] key     [N];
    logic [IW-1:0] rank    [N];
    logic [IW-1:0] j;
    logic [N-1:0]  prec;
    logic [DW-1:0] data_q  [N];
    logic [IW-1:0] idx_q   [N];
    logic [IW-1:0] rank_q  [N];
`ifdef SORT_RANK_DESC_EN
    logic          desc_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid && in_ready) next_state = RANK;
            RANK:    if (j == J_LAST)          next_state = SCATTER;
            SCATTER:                           next_state = DONE;
            DONE:    if (out_ready)            next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    // Handshake flags are decoded from next_state so they are registered yet track the state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            busy      <= (next_state != IDLE);
            out_valid <= (next_state == DONE);
        end
    end

    // Column j beats key i when it sorts strictly earlier, or ties with a lower index.
    always_comb begin
        prec = '0;
        for (int i = 0; i < N; i++) begin
            logic ahead;
`ifdef SORT_RANK_DESC_EN
            ahead = desc_q ? (key[j] > key[i]) : (key[j] < key[i]);
`else
            ahead = (key[j] < key[i]);
`endif
            prec[i] = ahead || ((key[j] == key[i]) && (j < IW'(i)));
        end
    end

    // NOTE: these register arrays are reset explicitly because the cleared outputs are observable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j <= '0;
`ifdef SORT_RANK_DESC_EN
            desc_q <= 1'b0;
`endif
            for (int i = 0; i < N; i++) begin
                key[i]    <= '0;
                rank[i]   <= '0;
                data_q[i] <= '0;
                idx_q[i]  <= '0;
                rank_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    j <= '0;
`ifdef SORT_RANK_DESC_EN
                    desc_q <= mode_desc;
`endif
                    for (int i = 0; i < N; i++) begin
                        key[i]  <= in_data[i*DW +: DW];
                        rank[i] <= '0;
                    end
                end
                RANK: begin
                    j <= j + IW'(1);
                    for (int i = 0; i < N; i++)
                        rank[i] <= rank[i] + IW'(prec[i]);
                end
                SCATTER: begin
                    for (int i = 0; i < N; i++) begin
                        data_q[rank[i]] <= key[i];
                        idx_q[rank[i]]  <= IW'(i);
                        rank_q[i]       <= rank[i];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign out_data[g*DW +: DW] = data_q[g];
        assign out_idx[g*IW +: IW]  = idx_q[g];
        assign out_rank[g*IW +: IW] = rank_q[g];
    end

endmodule

// File: tb/tb_sort_rank_seq.sv
// Scoreboard bench for sort_rank_seq: a stable selection-sort model predicts each result,
// a negedge monitor compares every cycle out_valid is high and retires entries on handshake.
module tb_sort_rank_seq;
    localparam int N  = 16;
    localparam int DW = 20;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            mode_desc;
    logic            out_valid;
    logic            out_ready;
    logic [N*DW-1:0] out_data;
    logic [N*IW-1:0] out_idx;
    logic [N*IW-1:0] out_rank;
    logic            busy;

    typedef struct {
        logic [N*DW-1:0] data;
        logic [N*IW-1:0] idx;
        logic [N*IW-1:0] rank;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] k [N];

    sort_rank_seq #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SORT_RANK_DESC_EN
        .mode_desc (mode_desc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_rank  (out_rank),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stable sort by repeated selection: take the best remaining key, lowest index on ties.
    function automatic exp_t model(input logic [N*DW-1:0] d, input bit desc);
        exp_t e;
        bit   used [N];
        e.data = '0; e.idx = '0; e.rank = '0;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int s = 0; s < N; s++) begin
            int best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i]) begin
                    if (best < 0) best = i;
                    else if (desc ? (d[i*DW +: DW] > d[best*DW +: DW])
                                  : (d[i*DW +: DW] < d[best*DW +: DW])) best = i;
                end
            end
            used[best] = 1'b1;
            e.data[s*DW +: DW]    = d[best*DW +: DW];
            e.idx[s*IW +: IW]     = IW'(best);
            e.rank[best*IW +: IW] = IW'(s);
        end
        return e;
    endfunction

    function automatic logic [N*DW-1:0] pack_keys();
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = k[i];
        return d;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                check("out_data", out_data, sb[0].data);
                check("out_idx",  out_idx,  sb[0].idx);
                check("out_rank", out_rank, sb[0].rank);
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [N*DW-1:0] d, input bit desc, input int bp);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_idle", in_ready, 1'b1);
        in_data   = d;
        in_valid  = 1'b1;
        mode_desc = desc;
        out_ready = (bp == 0);
        sb.push_back(model(d, desc));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        mode_desc = ~desc;
        in_data   = {N*DW{1'b1}} ^ d;
        check("in_ready_after_accept", in_ready, 1'b0);
        check("busy_after_accept", busy, 1'b1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 50);
        check("latency", n, N + 1);
        for (int c = 0; c < bp; c++) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            in_valid = (c == 3);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("out_valid_after_hs", out_valid, 1'b0);
        check("in_ready_after_hs", in_ready, 1'b1);
        check("busy_after_hs", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; mode_desc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_out_idx", out_idx, '0);
        check("rst_out_rank", out_rank, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) k[i] = DW'(N - 1 - i);
        send(pack_keys(), 1'b0, 0);

        for (int i = 0; i < N; i++) k[i] = 20'h5A5A5;
        send(pack_keys(), 1'b0, 0);

        k = '{20'h00123, 20'hFFFFF, 20'h00010, 20'h00123, 20'h00000, 20'h80000, 20'hFFFFF, 20'h00010,
              20'h7FFFF, 20'h00001, 20'h00123, 20'h40000, 20'h00002, 20'hABCDE, 20'h00003, 20'h00004};
        send(pack_keys(), 1'b0, 0);
        send(pack_keys(), 1'b0, 10);

        // Reset while ranking: abandon the vector at column 7.
        for (int i = 0; i < N; i++) k[i] = DW'($urandom);
        in_data  = pack_keys();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrank_out_valid", out_valid, 1'b0);
        check("midrank_busy", busy, 1'b0);
        check("midrank_in_ready", in_ready, 1'b1);
        check("midrank_out_data", out_data, '0);
        check("midrank_out_idx", out_idx, '0);
        check("midrank_out_rank", out_rank, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) k[i] = DW'($urandom);
        send(pack_keys(), 1'b0, 0);

`ifdef SORT_RANK_DESC_EN
        for (int i = 0; i < N; i++) k[i] = DW'(i);
        send(pack_keys(), 1'b1, 0);
`endif

        for (int t = 0; t < 10; t++) begin
            bit desc;
            desc = 1'b0;
`ifdef SORT_RANK_DESC_EN
            desc = 1'($urandom_range(0, 1));
`endif
            for (int i = 0; i < N; i++)
                k[i] = (t % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            send(pack_keys(), desc, int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sort_rank_seq.md
# sort_rank_seq

Parametrised successor to the 16-channel, 20-bit parallel rank sorter. It accepts one vector of N keys through a valid/ready handshake and builds each key's rank iteratively, one comparison column per cycle. It then scatters the keys into sorted order and holds the result until the consumer accepts it. It sits between the comparison-feature stage and the score/selection logic, and additionally outputs the original index of every sorted slot and a stable tie-break.

## Interface
- `N`, default 16: number of channels; legal range N ≥ 2.
- `DW`, default 20: key width in bits, unsigned.
- `IW`, default `$clog2(N)`: derived localparam; width of rank and index fields.
- `clk` input, 1 bit: single clock. All logic is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: input vector valid.
- `in_ready` output, 1 bit: block can accept a vector.
- `in_data` input, N*DW bits: key i occupies `[i*DW +: DW]`.
- `mode_desc` input, 1 bit: descending order when 1. Present only with `SORT_RANK_DESC_EN` defined.
- `out_valid` output, 1 bit: sorted result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_data` output, N*DW bits: sorted key in slot k at `[k*DW +: DW]`. Slot 0 is first in sort order.
- `out_idx` output, N*IW bits: original input index of slot k.
- `out_rank` output, N*IW bits: final rank of input i, i.e. its slot number.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- FSM states: IDLE, RANK, SCATTER, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`&&`in_ready`: latch `in_data` (and `mode_desc`), clear all rank accumulators and the column counter j, then go to RANK.
- RANK: lasts N cycles, with j from 0 to N-1.
  - Each cycle, for every i in parallel: rank[i] += prec(j,i).
  - j increments each cycle. When j==N-1 the state goes to SCATTER.
- Precedence rule prec(j,i):
  - Ascending: key[j] < key[i], or key[j]==key[i] and j < i.
  - Descending: key[j] > key[i], or key[j]==key[i] and j < i.
  - prec(i,i)=0.
  - This rule guarantees the ranks form a permutation of 0..N-1, including when keys tie. Ties keep input order (stable sort).
- SCATTER: one cycle. For every i: `out_data` slot rank[i] ← key[i], `out_idx` slot rank[i] ← i, `out_rank[i]` ← rank[i]. Set `out_valid`=1 and go to DONE.
- DONE:
  - Outputs are held stable.
  - When `out_ready`=1, clear `out_valid` and go to IDLE.
  - Output registers keep their last values after handshake; they are cleared only by reset.
- `in_valid` in any state other than IDLE is ignored. No vector is lost because `in_ready`=0 in those states.
- Rank accumulators are IW bits wide. The maximum value is N-1, so they never overflow.
- Comparisons are unsigned on the full DW bits.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0. `out_data`, `out_idx` and `out_rank` are all zero. The FSM is in IDLE, j=0 and the internal key registers are zero.
- Accept happens at edge E0. RANK accumulates at edges E1..EN, and the state moves to SCATTER at EN. `out_valid` rises after edge E(N+1).
- Latency from accept to `out_valid` is N+1 cycles, i.e. 17 cycles for N=16.
- `out_valid` rising and `out_ready` already high: the handshake completes at the next edge; the block is in IDLE one cycle after `out_valid` first shows.
- Earliest next accept is one cycle after the output handshake. Minimum period is N+3 cycles per vector.
- `in_ready` is a registered decode of the state (IDLE) with no combinational path from `out_ready`.
- `rst` asserted mid-RANK, mid-SCATTER or in DONE: the FSM returns to IDLE immediately (asynchronously) and all outputs return to their reset values. The partial result is discarded and no `out_valid` is ever produced for it.

## Configuration
- `SORT_RANK_DESC_EN` defined:
  - The `mode_desc` port exists and is sampled at accept.
  - The latched value selects ascending or descending order for that vector only.
  - Changing `mode_desc` after accept has no effect on the vector in flight.
- `SORT_RANK_DESC_EN` undefined: the port is absent, sort order is ascending only, and the descending comparator logic is not built.

## Test plan
- Reverse input, N=16, DW=20. Keys: i=0 is 15, i=1 is 14, …, i=15 is 0. Required: `out_data` slot k = k, `out_idx` slot k = 15-k, `out_rank[i]`=15-i. `out_valid` rises 17 cycles after accept.
- All keys tied, every key 0x5A5A5. Required: `out_idx` slot k = k and `out_rank[i]`=i (stable order).
- Mixed keys with duplicates and the extreme values 0xFFFFF and 0. Required: 0 is in slot 0, both 0xFFFFF keys are in slots 14 and 15, and the lower input index of the pair is in slot 14.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` rises. Required:
  - Outputs stay stable.
  - `in_ready`=0 throughout.
  - A second `in_valid` pulse during DONE is ignored.
  - After `out_ready`=1, the handshake completes and `in_ready`=1 on the next cycle.
- Reset in RANK: assert `rst` at j=7. Required: `out_valid`, `busy` and all outputs are 0 and `in_ready`=1 at once. A new vector after reset sorts correctly with 17-cycle latency.
- With `SORT_RANK_DESC_EN`: keys 0..15 in order with `mode_desc`=1, and `mode_desc` toggled after accept. Required: `out_data` slot k = 15-k, unaffected by the toggle.
